// File: rtl/processor_pkg.sv
// Shared decode/ALU definitions: operation codes, opcode constants and the
// decoded-beat record carried through the decode stage buffers.
package processor_pkg;

    localparam int unsigned PC_ADDR_W = 32;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_ADDI  = 5'd10;
    localparam logic [4:0] ALU_SLTI  = 5'd11;
    localparam logic [4:0] ALU_SLTIU = 5'd12;
    localparam logic [4:0] ALU_XORI  = 5'd13;
    localparam logic [4:0] ALU_ORI   = 5'd14;
    localparam logic [4:0] ALU_ANDI  = 5'd15;
    localparam logic [4:0] ALU_SLLI  = 5'd16;
    localparam logic [4:0] ALU_SRLI  = 5'd17;
    localparam logic [4:0] ALU_SRAI  = 5'd18;
    localparam logic [4:0] ALU_LUI   = 5'd19;
    localparam logic [4:0] ALU_AUIPC = 5'd20;
    // Outside every ALU case, so the ALU performs no register write.
    localparam logic [4:0] ALU_NOP   = 5'd31;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [PC_ADDR_W-1:0] pc;
        logic [4:0]           alu_control;
        logic [31:0]          imm;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 illegal;
    } decode_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Combinational RV32I decoder for the OP, OP-IMM, LUI and AUIPC groups.
module rv32i_decode_comb
    import processor_pkg::*;
(
    input  logic [31:0]          instr_i,
    input  logic [PC_ADDR_W-1:0] pc_i,
    output decode_t              dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] shamt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign shamt  = instr_i[24:20];

    always_comb begin
        dec_o             = '0;
        dec_o.pc          = pc_i;
        dec_o.rs1         = instr_i[19:15];
        dec_o.rs2         = instr_i[24:20];
        dec_o.rd          = instr_i[11:7];
        dec_o.alu_control = ALU_NOP;
        dec_o.illegal     = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_o.alu_control = ALU_ADD;
                        3'b001:  dec_o.alu_control = ALU_SLL;
                        3'b010:  dec_o.alu_control = ALU_SLT;
                        3'b011:  dec_o.alu_control = ALU_SLTU;
                        3'b100:  dec_o.alu_control = ALU_XOR;
                        3'b101:  dec_o.alu_control = ALU_SRL;
                        3'b110:  dec_o.alu_control = ALU_OR;
                        default: dec_o.alu_control = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_o.alu_control = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_o.alu_control = ALU_SRA;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_o.rs2 = '0;
                dec_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
                case (funct3)
                    3'b000: dec_o.alu_control = ALU_ADDI;
                    3'b010: dec_o.alu_control = ALU_SLTI;
                    3'b011: dec_o.alu_control = ALU_SLTIU;
                    3'b100: dec_o.alu_control = ALU_XORI;
                    3'b110: dec_o.alu_control = ALU_ORI;
                    3'b111: dec_o.alu_control = ALU_ANDI;
                    default: begin
                        // Shift amount is presented bit-reversed to match the ALU.
                        dec_o.imm = {27'd0, shamt[0], shamt[1], shamt[2], shamt[3], shamt[4]};
                        if (funct3 == 3'b001 && funct7 == 7'b0000000)
                            dec_o.alu_control = ALU_SLLI;
                        else if (funct3 == 3'b101 && funct7 == 7'b0000000)
                            dec_o.alu_control = ALU_SRLI;
                        else if (funct3 == 3'b101 && funct7 == 7'b0100000)
                            dec_o.alu_control = ALU_SRAI;
                        else
                            dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_o.rs1         = '0;
                dec_o.rs2         = '0;
                dec_o.imm         = {instr_i[31:12], 12'd0};
                dec_o.alu_control = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            default: dec_o.illegal = 1'b1;
        endcase

        if (dec_o.illegal) begin
            dec_o.alu_control = ALU_NOP;
            dec_o.rd          = '0;
            dec_o.imm         = '0;
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: valid/ready handshake with an output register
// plus one skid entry so backpressure never drops a beat.
module rv32i_decode_stage
    import processor_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_alu_control,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [4:0]      out_rd_addr,
    output logic            out_illegal
);

    decode_t dec_in;
    decode_t out_q, out_d;
    decode_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept;
    logic    drain;

    rv32i_decode_comb u_decode (
        .instr_i (in_instr),
        .pc_i    (PC_ADDR_W'(in_pc)),
        .dec_o   (dec_in)
    );

    assign in_ready = !skid_valid_q && !flush;
    assign accept   = in_valid && in_ready;
    assign drain    = !out_valid_q || out_ready;

    // A skid entry only exists while in_ready is low, so draining it and
    // accepting a new beat never happen on the same edge.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_in;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_in;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = PC_W'(out_q.pc);
    assign out_alu_control = out_q.alu_control;
    assign out_imm         = out_q.imm;
    assign out_rs1_addr    = out_q.rs1;
    assign out_rs2_addr    = out_q.rs2;
    assign out_rd_addr     = out_q.rd;
    assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed scoreboard bench for rv32i_decode_stage.
module tb_rv32i_decode_stage;
    import processor_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_alu_control;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1_addr;
    logic [4:0]  out_rs2_addr;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    rv32i_decode_stage #(.PC_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_alu_control (out_alu_control),
        .out_imm         (out_imm),
        .out_rs1_addr    (out_rs1_addr),
        .out_rs2_addr    (out_rs2_addr),
        .out_rd_addr     (out_rd_addr),
        .out_illegal     (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(logic [31:0] pc, logic [4:0] alu, logic [31:0] imm,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic ill);
        exp_t e;
        e.pc = pc; e.alu = alu; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_beat observed=pc 0x%08h expected=no beat", out_pc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat_pc",      out_pc,                 e.pc);
            chk("beat_alu",     32'(out_alu_control),   32'(e.alu));
            chk("beat_imm",     out_imm,                e.imm);
            chk("beat_rs1",     32'(out_rs1_addr),      32'(e.rs1));
            chk("beat_rs2",     32'(out_rs2_addr),      32'(e.rs2));
            chk("beat_rd",      32'(out_rd_addr),       32'(e.rd));
            chk("beat_illegal", 32'(out_illegal),       32'(e.ill));
        end
    endtask

    // Called just after a falling edge; evaluates the handshake before the next rising edge.
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input exp_t e, input logic ordy, input logic fl, output logic acc);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (out_valid && out_ready && !flush) pop_check();
        acc = in_valid && in_ready;
        if (acc) sb.push_back(e);
        if (fl) begin
            chk("flush_in_ready", 32'(in_ready), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        drive(1'b0, 32'd0, 32'd0, '0, ordy, 1'b0, acc);
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid),       32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),        32'd1);
        chk({tag, "_pc"},        out_pc,               32'd0);
        chk({tag, "_alu"},       32'(out_alu_control), 32'd0);
        chk({tag, "_imm"},       out_imm,              32'd0);
        chk({tag, "_rd"},        32'(out_rd_addr),     32'd0);
        chk({tag, "_illegal"},   32'(out_illegal),     32'd0);
    endtask

    initial begin
        logic acc;
        exp_t e_addi, e_sub, e_srai, e_lw, e_lui, e_a, e_b, e_c, e_auipc;

        e_addi  = mk(32'h100, ALU_ADDI,  32'hFFFFFFFB, 5'd2,  5'd0, 5'd1, 1'b0);
        e_sub   = mk(32'h104, ALU_SUB,   32'h0,        5'd4,  5'd5, 5'd3, 1'b0);
        e_srai  = mk(32'h108, ALU_SRAI,  32'h00000018, 5'd1,  5'd0, 5'd1, 1'b0);
        e_lw    = mk(32'h10C, ALU_NOP,   32'h0,        5'd0,  5'd0, 5'd0, 1'b1);
        e_lui   = mk(32'h110, ALU_LUI,   32'h12345000, 5'd0,  5'd0, 5'd5, 1'b0);
        e_a     = mk(32'h200, ALU_ADD,   32'h0,        5'd7,  5'd8, 5'd6, 1'b0);
        e_b     = mk(32'h204, ALU_XORI,  32'h000007FF, 5'd10, 5'd0, 5'd9, 1'b0);
        e_c     = mk(32'h208, ALU_SLLI,  32'h00000010, 5'd3,  5'd0, 5'd2, 1'b0);
        e_auipc = mk(32'h300, ALU_AUIPC, 32'hABCDE000, 5'd0,  5'd0, 5'd7, 1'b0);

        repeat (2) @(negedge clk);
        reset_outputs_check("reset");
        rst = 1'b0;
        @(negedge clk);

        drive(1'b1, 32'hFFB10093, 32'h100, e_addi, 1'b1, 1'b0, acc);
        chk("addi_latency_valid", 32'(out_valid), 32'd1);
        idle(1'b1);

        drive(1'b1, 32'h405201B3, 32'h104, e_sub,  1'b1, 1'b0, acc);
        drive(1'b1, 32'h4030D093, 32'h108, e_srai, 1'b1, 1'b0, acc);
        drive(1'b1, 32'h00000003, 32'h10C, e_lw,   1'b1, 1'b0, acc);
        drive(1'b1, 32'h123452B7, 32'h110, e_lui,  1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A held in the output register, B in skid, C refused.
        drive(1'b1, 32'h00838333, 32'h200, e_a, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h7FF54493, 32'h204, e_b, 1'b0, 1'b0, acc);
        chk("bp_b_accepted", 32'(acc), 32'd1);
        drive(1'b1, 32'h00119113, 32'h208, e_c, 1'b0, 1'b0, acc);
        chk("bp_c_refused", 32'(acc), 32'd0);
        chk("bp_hold_pc", out_pc, 32'h200);
        chk("bp_hold_alu", 32'(out_alu_control), 32'(ALU_ADD));
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++)
            drive(1'b1, 32'h00119113, 32'h208, e_c, 1'b1, 1'b0, acc);
        chk("bp_c_eventually_accepted", 32'(acc), 32'd1);
        repeat (3) idle(1'b1);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Flush with both entries full and a beat offered.
        drive(1'b1, 32'hFFB10093, 32'h400, e_addi, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h405201B3, 32'h404, e_sub,  1'b0, 1'b0, acc);
        drive(1'b1, 32'h4030D093, 32'h408, e_srai, 1'b1, 1'b1, acc);
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);
        repeat (3) idle(1'b1);

        // Asynchronous reset with both entries full.
        drive(1'b1, 32'hFFB10093, 32'h500, e_addi, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h405201B3, 32'h504, e_sub,  1'b0, 1'b0, acc);
        chk("prereset_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        reset_outputs_check("midreset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (3) idle(1'b1);

        drive(1'b1, 32'hABCDE397, 32'h300, e_auipc, 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);
        chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
